// File: rtl/ep_ctx_rmw_engine_pkg.sv
// Shared types and field layout for the endpoint-context read-modify-write engine.
// Field offsets follow the xHCI endpoint context dwords 0 (state) and 2/3 (dequeue pointer + DCS).
package ep_ctx_rmw_engine_pkg;

  typedef enum logic [2:0] {
    EP_DISABLED = 3'd0,
    EP_RUNNING  = 3'd1,
    EP_HALTED   = 3'd2,
    EP_STOPPED  = 3'd3,
    EP_ERROR    = 3'd4
  } ep_state_t;

  typedef struct packed {
    logic deq;    // write TR dequeue pointer + DCS
    logic state;  // write EP state
  } ctx_op_t;

  localparam int unsigned STATE_LSB   = 0;
  localparam int unsigned DCS_BIT     = 64;
  localparam int unsigned DEQ_LSB     = 68;
  localparam int unsigned SET_EP_TR_W = 74;

  function automatic logic [SET_EP_TR_W-1:0] pack_set_ep_tr(
    input logic        dcs,
    input logic [63:4] deq_hi,
    input logic [4:0]  dci,
    input logic [2:0]  slot_lo,
    input logic        run
  );
    return {dcs, deq_hi, 4'h0, dci, slot_lo, run};
  endfunction

  function automatic logic [127:0] patch_beat0(
    input logic [127:0] beat,
    input ctx_op_t      op,
    input ep_state_t    st,
    input logic         dcs,
    input logic [63:4]  deq_hi
  );
    logic [127:0] b;
    b = beat;
    if (op.state) b[STATE_LSB +: 3] = st;
    if (op.deq) begin
      b[DCS_BIT]       = dcs;
      b[DEQ_LSB +: 60] = deq_hi;
    end
    return b;
  endfunction

endpackage

// File: rtl/ep_ctx_rmw_engine_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted requester.
// The pointer only moves on an advance strobe that actually produced a grant.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned c;
      c = 32'(r_ptr) + k;
      if (c >= N) c = c - N;
      if (!o_any && i_req[c]) begin
        o_any      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = IW'(c);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_any) begin
      r_ptr <= (32'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ep_ctx_rmw_engine.sv
// Endpoint-context RMW engine: arbitrate a client, read its EP context, patch
// state and/or dequeue pointer in beat 0, write it back, mirror dequeue updates on set_ep_tr.
module ep_ctx_rmw_engine
  import ep_ctx_rmw_engine_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned MAX_SLOTS = 8,
  parameter bit          CTX64     = 1'b0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [2*N_REQ-1:0]       i_req_op,
  input  logic [8*N_REQ-1:0]       i_req_slot,
  input  logic [5*N_REQ-1:0]       i_req_dci,
  input  logic [3*N_REQ-1:0]       i_req_state,
  input  logic [64*N_REQ-1:0]      i_req_deq,
  input  logic [N_REQ-1:0]         i_req_dcs,
  output logic [N_REQ-1:0]         o_req_done,
  output logic [N_REQ-1:0]         o_req_err,
  input  logic [64*MAX_SLOTS-1:0]  i_ctx_ptr,
  output logic                     o_rd_req,
  input  logic                     i_rd_ack,
  output logic [63:0]              o_rd_addr,
  output logic [31:0]              o_rd_len,
  input  logic                     i_rd_valid,
  input  logic [127:0]             i_rd_data,
  output logic                     o_wr_req,
  input  logic                     i_wr_ack,
  output logic [63:0]              o_wr_addr,
  output logic [31:0]              o_wr_len,
  output logic                     o_wr_valid,
  input  logic                     i_wr_ready,
  output logic [127:0]             o_wr_data,
  input  logic                     i_wr_cpl,
  output logic [SET_EP_TR_W-1:0]   o_set_ep_tr
);

  localparam int unsigned IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SZ_SHIFT  = CTX64 ? 6 : 5;
  localparam logic [31:0] CTX_LEN   = CTX64 ? 32'd64 : 32'd32;
  localparam logic [1:0]  LAST_BEAT = CTX64 ? 2'd3 : 2'd1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ARB     = 4'd1;
  localparam logic [3:0] S_CHECK   = 4'd2;
  localparam logic [3:0] S_RD_REQ  = 4'd3;
  localparam logic [3:0] S_RD_DATA = 4'd4;
  localparam logic [3:0] S_MODIFY  = 4'd5;
  localparam logic [3:0] S_WR_REQ  = 4'd6;
  localparam logic [3:0] S_WR_DATA = 4'd7;
  localparam logic [3:0] S_WR_WAIT = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  logic [3:0]       r_state;
  logic [N_REQ-1:0] r_grant;
  ctx_op_t          r_op;
  logic [7:0]       r_slot;
  logic [4:0]       r_dci;
  ep_state_t        r_ep_state;
  logic [63:4]      r_deq_hi;
  logic             r_dcs;
  logic             r_err;
  logic             r_run;
  logic [63:0]      r_addr;
  logic [1:0]       r_beat;
  logic [127:0]     r_buf [4];

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic [1:0]       w_g_op;
  logic [7:0]       w_g_slot;
  logic [4:0]       w_g_dci;
  logic [2:0]       w_g_state;
  logic [63:0]      w_g_deq;
  logic             w_g_dcs;
  logic [63:0]      w_base;
  logic [63:0]      w_off;
  logic             w_bad;
  logic             w_unused_deq_lsb;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req     (i_req_valid),
    .i_advance (r_state == S_ARB),
    .o_grant   (w_grant),
    .o_idx     (w_gidx),
    .o_any     (w_any)
  );

  always_comb begin
    w_g_op    = '0;
    w_g_slot  = '0;
    w_g_dci   = '0;
    w_g_state = '0;
    w_g_deq   = '0;
    w_g_dcs   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (k == 32'(w_gidx)) begin
        w_g_op    = i_req_op[2*k +: 2];
        w_g_slot  = i_req_slot[8*k +: 8];
        w_g_dci   = i_req_dci[5*k +: 5];
        w_g_state = i_req_state[3*k +: 3];
        w_g_deq   = i_req_deq[64*k +: 64];
        w_g_dcs   = i_req_dcs[k];
      end
    end
  end

  assign w_unused_deq_lsb = ^w_g_deq[3:0];

  // Slot ids are 1-based; an out-of-range slot never reaches the address path.
  always_comb begin
    w_base = '0;
    for (int unsigned k = 0; k < MAX_SLOTS; k++) begin
      if (r_slot == 8'(k + 1)) w_base = i_ctx_ptr[64*k +: 64];
    end
  end

  assign w_off = {59'b0, r_dci} << SZ_SHIFT;
  assign w_bad = (r_slot == 8'd0) || (r_slot > 8'(MAX_SLOTS)) ||
                 (r_dci == 5'd0) || (r_op == '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_op       <= '0;
      r_slot     <= '0;
      r_dci      <= '0;
      r_ep_state <= EP_DISABLED;
      r_deq_hi   <= '0;
      r_dcs      <= 1'b0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
      r_addr     <= '0;
      r_beat     <= '0;
      for (int unsigned i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      r_run <= 1'b0;
      case (r_state)
        S_IDLE: if (|i_req_valid) r_state <= S_ARB;
        S_ARB: begin
          if (w_any) begin
            r_grant    <= w_grant;
            r_op       <= ctx_op_t'(w_g_op);
            r_slot     <= w_g_slot;
            r_dci      <= w_g_dci;
            r_ep_state <= ep_state_t'(w_g_state);
            r_deq_hi   <= w_g_deq[63:4];
            r_dcs      <= w_g_dcs;
            r_state    <= S_CHECK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
          r_err   <= w_bad;
          r_addr  <= w_base + w_off;
          r_state <= w_bad ? S_DONE : S_RD_REQ;
        end
        S_RD_REQ: begin
          r_beat <= '0;
          if (i_rd_ack) r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (i_rd_valid) begin
            r_buf[r_beat] <= i_rd_data;
            if (r_beat == LAST_BEAT) r_state <= S_MODIFY;
            else                     r_beat  <= r_beat + 2'd1;
          end
        end
        S_MODIFY: begin
          r_buf[0] <= patch_beat0(r_buf[0], r_op, r_ep_state, r_dcs, r_deq_hi);
          r_beat   <= '0;
          r_state  <= S_WR_REQ;
        end
        S_WR_REQ: if (i_wr_ack) r_state <= S_WR_DATA;
        S_WR_DATA: begin
          if (i_wr_ready) begin
            if (r_beat == LAST_BEAT) r_state <= S_WR_WAIT;
            else                     r_beat  <= r_beat + 2'd1;
          end
        end
        S_WR_WAIT: begin
          if (i_wr_cpl) begin
            r_run   <= r_op.deq;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (!(|(i_req_valid & r_grant))) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_done  = (r_state == S_DONE) ? r_grant : '0;
  assign o_req_err   = (r_state == S_DONE && r_err) ? r_grant : '0;
  assign o_rd_req    = (r_state == S_RD_REQ);
  assign o_rd_addr   = o_rd_req ? r_addr : '0;
  assign o_rd_len    = o_rd_req ? CTX_LEN : '0;
  assign o_wr_req    = (r_state == S_WR_REQ);
  assign o_wr_addr   = o_wr_req ? r_addr : '0;
  assign o_wr_len    = o_wr_req ? CTX_LEN : '0;
  assign o_wr_valid  = (r_state == S_WR_DATA);
  assign o_wr_data   = o_wr_valid ? r_buf[r_beat] : '0;
  assign o_set_ep_tr = r_run ? pack_set_ep_tr(r_dcs, r_deq_hi, r_dci, r_slot[2:0], 1'b1) : '0;

endmodule
